axis_frame_tx: RTL and testbench

//  AXI-Stream frame transmitter: initiator side feeding the stream memory's slave port.

---
 rtl/axis_frame_tx_if.sv | 21 ++
 rtl/axis_frame_tx.sv | 174 +++++++++++++++++
 tb/tb_axis_frame_tx.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_tx_if.sv
// AXI-Stream beat bundle between axis_frame_tx and its downstream sink.
// Master drives data/strobe/valid/last; slave returns tready.
interface axis_frame_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (
    output tdata, tstrb, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_frame_tx.sv
// FIFO-backed AXI-Stream frame transmitter: FRAME_LEN-beat frames, flush for short ones.
// Optional AXIS_TX_FRAME_CNT_EN adds frame_count and drop_pulse outputs.
module axis_frame_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FRAME_LEN  = 8
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_full,
  input  logic                  flush,
`ifdef AXIS_TX_FRAME_CNT_EN
  output logic [15:0]           frame_count,
  output logic                  drop_pulse,
`endif
  axis_frame_tx_if.master       m00_axis
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] C_DEPTH =
    (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] C_FLEN =
    (ADDR_WIDTH+1)'(FRAME_LEN);
  localparam logic [ADDR_WIDTH:0] C_ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] C_TWO =
    (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH-1:0] C_PINC =
    ADDR_WIDTH'(1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_remain;
  logic                  r_flush_pend;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [SW-1:0]         r_tstrb;
  logic                  r_tvalid;
  logic                  r_tlast;

  logic                  w_full;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_next;
  logic                  w_pop;
  logic                  w_push;
  logic [ADDR_WIDTH:0]   w_len;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_full   = (r_count == C_DEPTH);
  assign w_start  = (r_state == S_IDLE) &&
                    ((r_count >= C_FLEN) ||
                     (r_flush_pend && (r_count != '0)));
  assign w_accept = r_tvalid && m00_axis.tready;
  assign w_next   = (r_state == S_SEND) && w_accept &&
                    (r_remain > C_ONE);
  assign w_pop    = w_start || w_next;
  // A pop on the same edge frees a slot, so a push at full still lands
  assign w_push   = load_valid && (!w_full || w_pop);
  assign w_len    = (r_count >= C_FLEN) ? C_FLEN : r_count;
  assign w_rdata  = r_mem[r_rd_ptr];

  always_ff @(posedge m00_axis_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PINC;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PINC;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_state      <= S_IDLE;
      r_tdata      <= '0;
      r_tstrb      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_remain     <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_start) begin
        r_flush_pend <= flush;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end else if (r_flush_pend && (r_count == '0)) begin
        r_flush_pend <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_tdata  <= w_rdata;
            r_tstrb  <= '1;
            r_tvalid <= 1'b1;
            r_tlast  <= (w_len == C_ONE);
            r_remain <= w_len;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            if (r_remain > C_ONE) begin
              r_tdata  <= w_rdata;
              r_tlast  <= (r_remain == C_TWO);
              r_remain <= r_remain - C_ONE;
            end else begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_tstrb  <= '0;
              r_remain <= '0;
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_full       = w_full;
  assign m00_axis.tdata  = r_tdata;
  assign m00_axis.tstrb  = r_tstrb;
  assign m00_axis.tvalid = r_tvalid;
  assign m00_axis.tlast  = r_tlast;

`ifdef AXIS_TX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  logic        r_drop;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_frame_cnt <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= load_valid && w_full && !w_pop;
      if (w_accept && r_tlast) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign frame_count = r_frame_cnt;
  assign drop_pulse  = r_drop;
`endif

endmodule

// File: tb/tb_axis_frame_tx.sv
// Self-checking bench for axis_frame_tx: vector table, directed corners,
// and a queue-based scoreboard under randomized load/ready traffic.
module tb_axis_frame_tx;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_full;
  logic          flush = 1'b0;
`ifdef AXIS_TX_FRAME_CNT_EN
  logic [15:0]   frame_count;
  logic          drop_pulse;
`endif

  axis_frame_tx_if #(.DATA_WIDTH(DW)) axis ();

  axis_frame_tx #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(16),
    .ADDR_WIDTH(4),
    .FRAME_LEN(8)
  ) dut (
    .m00_axis_aclk(clk),
    .m00_axis_aresetn(rst_n),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_full(load_full),
    .flush(flush),
`ifdef AXIS_TX_FRAME_CNT_EN
    .frame_count(frame_count),
    .drop_pulse(drop_pulse),
`endif
    .m00_axis(axis)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic lv, input logic [DW-1:0] ld,
                     input logic fl, input logic tr);
    load_valid  = lv;
    load_data   = ld;
    flush       = fl;
    axis.tready = tr;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] gd[$];
  logic          gl[$];

  task automatic collect(input int n, input int budget);
    int waited;
    waited = 0;
    gd.delete();
    gl.delete();
    while (gd.size() < n && waited < budget) begin
      if (axis.tvalid) begin
        gd.push_back(axis.tdata);
        gl.push_back(axis.tlast);
      end
      cyc(1'b0, '0, 1'b0, 1'b1);
      waited++;
    end
    if (gd.size() < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL collect_timeout: got %0d beats, required %0d",
               gd.size(), n);
    end
  endtask

  task automatic check_frame(input string nm, input logic [DW-1:0] base,
                             input int off, input int n);
    for (int i = 0; i < n && (off + i) < gd.size(); i++) begin
      check($sformatf("%s_beat%0d", nm, i),
            {31'h0, gl[off+i], gd[off+i]},
            {31'h0, 1'(i == n - 1), DW'(base + DW'(i))});
    end
  endtask

  task automatic expect_quiet(input string nm, input int n,
                              input logic tr);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (axis.tvalid) seen++;
      cyc(1'b0, '0, 1'b0, tr);
    end
    check(nm, 64'(seen), 64'd0);
  endtask

  task automatic drain_idle(input string nm, input int budget);
    int idle;
    int w;
    idle = 0;
    w = 0;
    while (idle < 4 && w < budget) begin
      if (axis.tvalid) idle = 0;
      else idle++;
      cyc(1'b0, '0, 1'b0, 1'b1);
      w++;
    end
    if (idle < 4) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_drain_timeout: still busy after %0d cycles",
               nm, w);
    end
  endtask

  // Scoreboard: words leave in push order; frames are 8 beats except
  // the final flushed remainder, which ends on the last pushed word.
  logic          sb_on = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sb_e;
  int            sb_k = 0;
  int            sb_m = -1;
  int            n_last = 0;
  logic          pv = 1'b0;
  logic [DW-1:0] pd;
  logic          pl;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      n_last = 0;
    end else begin
      if (pv) begin
        check("axis_hold", {30'h0, axis.tvalid, axis.tlast, axis.tdata},
              {30'h0, 1'b1, pl, pd});
      end
      pv = axis.tvalid && !axis.tready;
      pd = axis.tdata;
      pl = axis.tlast;
      if (axis.tvalid && axis.tready) begin
        if (axis.tlast) n_last++;
        if (sb_on) begin
          sb_k++;
          if (exp_q.size() == 0) begin
            check("sb_extra_beat", 64'(axis.tdata), 64'hDEAD);
          end else begin
            sb_e = exp_q.pop_front();
            check("sb_data", 64'(axis.tdata), 64'(sb_e));
          end
          check("sb_last", 64'(axis.tlast),
                64'((sb_k % 8 == 0) || (sb_k == sb_m)));
          check("sb_strb", 64'(axis.tstrb), 64'hF);
        end
      end
    end
  end

  task automatic run_sb(input string nm, input int ncyc,
                        input bit fill, input bit rnd);
    int pushed;
    logic lv;
    logic tr;
    logic fp;
    logic [DW-1:0] d;
    pushed = 0;
    exp_q.delete();
    sb_k = 0;
    sb_m = -1;
    sb_on = 1'b1;
    if (fill) begin
      for (int i = 0; i < 40 && !load_full; i++) begin
        d = $urandom;
        exp_q.push_back(d);
        pushed++;
        cyc(1'b1, d, 1'b0, 1'b0);
      end
      // 16 in the FIFO plus one waiting in the output register
      check($sformatf("%s_fill_count", nm), 64'(pushed), 64'd17);
    end
    for (int c = 0; c < ncyc; c++) begin
      tr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      lv = !load_full || (axis.tvalid && tr && !axis.tlast);
      if (rnd) lv = lv && ($urandom_range(0, 1) == 1);
      fp = lv && load_full;
      d = $urandom;
      if (lv) begin
        exp_q.push_back(d);
        pushed++;
      end
      cyc(lv, d, 1'b0, tr);
      if (fp) check($sformatf("%s_full_hold", nm), 64'(load_full), 64'd1);
`ifdef AXIS_TX_FRAME_CNT_EN
      check($sformatf("%s_no_drop", nm), 64'(drop_pulse), 64'd0);
`endif
    end
    sb_m = pushed;
    drain_idle(nm, 300);
    cyc(1'b0, '0, 1'b1, 1'b1);
    drain_idle(nm, 100);
    check($sformatf("%s_beats", nm), 64'(sb_k), 64'(pushed));
    check($sformatf("%s_leftover", nm), 64'(exp_q.size()), 64'd0);
    sb_on = 1'b0;
  endtask

  typedef struct {
    logic       lv;
    logic [7:0] ld;
    logic       fl;
    logic       tr;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       ef;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 18; i++) begin
      tbl[i].fl = 1'b0;
      tbl[i].tr = 1'b1;
      tbl[i].ef = 1'b0;
      tbl[i].lv = (i < 8);
      tbl[i].ld = (i < 8) ? 8'(8'h10 + i) : 8'h00;
      tbl[i].ev = (i >= 8 && i < 16);
      tbl[i].ed = (i >= 8 && i < 16) ? 8'(8'h10 + i - 8) : 8'h00;
      tbl[i].el = (i == 15);
    end
    axis.tready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {28'h0, axis.tvalid, axis.tlast, axis.tstrb, load_full, axis.tdata},
          64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].lv, DW'(tbl[i].ld), tbl[i].fl, tbl[i].tr);
      check($sformatf("t1_row%0d", i),
            {25'h0, axis.tvalid, (axis.tvalid ? axis.tdata : '0),
             axis.tlast, axis.tstrb, load_full},
            {25'h0, tbl[i].ev, DW'(tbl[i].ed), tbl[i].el,
             (tbl[i].ev ? 4'hF : 4'h0), tbl[i].ef});
    end

    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'hA0 + i), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("t2_flush_latency", 64'(axis.tvalid), 64'd0);
    collect(3, 10);
    check_frame("t2_short", 32'hA0, 0, 3);
    expect_quiet("t2_idle", 5, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    expect_quiet("t2_empty_flush", 10, 1'b1);

    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(32'h30 + i), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      check($sformatf("t3_stall%0d", i),
            {31'h0, axis.tvalid, axis.tlast, axis.tdata},
            {31'h0, 1'b1, 1'b0, 32'h32});
    end
    collect(6, 20);
    check_frame("t3_resume", 32'h32, 0, 6);
    drain_idle("t3", 20);

    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, DW'(32'h40 + i), 1'b0, 1'b0);
      if (i == 15) check("t4_not_full16", 64'(load_full), 64'd0);
      if (i == 16) check("t4_full17", 64'(load_full), 64'd1);
    end
    check("t4_full_after_drop", 64'(load_full), 64'd1);
`ifdef AXIS_TX_FRAME_CNT_EN
    check("t4_drop_pulse", 64'(drop_pulse), 64'd1);
`endif
    cyc(1'b0, '0, 1'b0, 1'b0);
`ifdef AXIS_TX_FRAME_CNT_EN
    check("t4_drop_once", 64'(drop_pulse), 64'd0);
`endif
    collect(16, 60);
    check_frame("t4_frameA", 32'h40, 0, 8);
    check_frame("t4_frameB", 32'h48, 8, 8);
    expect_quiet("t4_residual_wait", 5, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    collect(1, 20);
    check_frame("t4_residual", 32'h50, 0, 1);
    expect_quiet("t4_dropped_gone", 10, 1'b1);
`ifdef AXIS_TX_FRAME_CNT_EN
    check("t4_frame_count", 64'(frame_count), 64'(n_last[15:0]));
`endif

    run_sb("t5_wrap", 60, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(32'h60 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    check("t6_beat4", {31'h0, axis.tvalid, axis.tdata},
          {31'h0, 1'b1, 32'h64});
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset",
          {28'h0, axis.tvalid, axis.tlast, axis.tstrb, load_full, axis.tdata},
          64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_quiet("t6_no_replay", 6, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    expect_quiet("t6_lost_fifo", 6, 1'b1);
`ifdef AXIS_TX_FRAME_CNT_EN
    check("t6_count_after_reset", 64'(frame_count), 64'd0);
`endif
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(32'h70 + i), 1'b0, 1'b1);
    expect_quiet("t6_seven_words", 3, 1'b1);
    cyc(1'b1, DW'(32'h77), 1'b0, 1'b1);
    collect(8, 20);
    check_frame("t6_new_frame", 32'h70, 0, 8);
    drain_idle("t6", 20);
`ifdef AXIS_TX_FRAME_CNT_EN
    check("t6_count_new", 64'(frame_count), 64'd1);
`endif

    run_sb("rand", 400, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
